clock_period_monitor: RTL and testbench
=======================================

Name: clock_period_monitor

Overview:
- Receive-side counterpart of the PIO clock divider: takes the divider's one-cycle-per-period enable pulse (tick) and recovers the divisor by measuring the cycle distance between ticks.
- Reports the measured period, a per-measurement strobe, a lock indication once the period is stable, and a timeout when ticks stop.
- Sits beside each state-machine clock divider for self-check and debug readback over the PIO register bus.

Parameters:
- WIDTH, 17, width of the period counter and the period output; matches the divisor width.
- LOCK_COUNT, 4, number of consecutive identical measurements required to assert locked; range 1..15.
- TIMEOUT, 131071, tick-free cycle count that declares loss of ticks; must satisfy 2 <= TIMEOUT <= 2^WIDTH-1.

Ports:
- clock, input, 1, sole clock; all logic on its rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- clear, input, 1, synchronous restart of measurement; returns the block to IDLE.
- tick, input, 1, enable pulse from the divider, sampled every cycle; high for N consecutive cycles counts as N ticks.
- period, output, WIDTH, most recent measured period in clock cycles.
- sample_valid, output, 1, one-cycle strobe; period was updated this cycle.
- locked, output, 1, high while the last LOCK_COUNT measurements were identical.
- timeout, output, 1, one-cycle strobe; TIMEOUT cycles elapsed with no tick.

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, match=0, period=0; sample_valid, locked and timeout all 0. Outputs go to these values immediately, without waiting for a clock edge.
- All outputs are registered. A tick sampled at edge k produces its effect on the outputs after edge k (one-cycle latency).
- cnt (WIDTH bits):
  - Loads 0 on every tick cycle.
  - Otherwise increments in ARMED and TRACK.
  - Held at 0 in IDLE.
- Measured value on a tick = cnt+1. Ticks at cycles t0 and t1 give t1-t0. tick held high permanently gives 1.
- States:
  - IDLE: waiting for the first tick. On tick, go to ARMED; no sample is produced.
  - ARMED: on tick, period <= cnt+1, sample_valid pulses, match <= 1, go to TRACK. locked=1 at this point only if LOCK_COUNT==1.
  - TRACK: on tick, sample_valid pulses.
    - If cnt+1 == period: match <= min(match+1, LOCK_COUNT).
    - Otherwise: period <= cnt+1, match <= 1, locked <= 0.
    - locked = (match == LOCK_COUNT) and the last measurement matched.
- Timeout (ARMED or TRACK): cnt == TIMEOUT-1 with no tick in that cycle.
  - timeout pulses 1 cycle, state goes to IDLE, locked <= 0, period <= 0, match <= 0.
  - A tick in that same cycle wins: the measurement TIMEOUT is taken normally and no timeout fires.
  - Maximum measurable period = TIMEOUT, so cnt never wraps.
- clear=1: next state IDLE, cnt/match/period/locked <= 0, no strobes. clear has priority over a simultaneous tick or timeout.
- sample_valid and timeout are never high in the same cycle.
- The first tick after reset, clear or timeout only arms the block; no sample is produced.

Test Plan:
- Lock on period 5: release reset, tick high 1 cycle in every 5. Expect no sample_valid at tick 1; period=5 with sample_valid 1 cycle after ticks 2..6; locked=1 after tick 5 (4th matching measurement) and held.
- Constant tick: tick stuck at 1. Expect period=1, sample_valid high every cycle from cycle 2 onward, locked after the 4th measurement.
- Period change: lock on period 5, then switch ticks to every 7 cycles. Expect the first 7-cycle measurement to give period=7 and locked drop the same cycle; locked re-asserts after the 4th consecutive 7.
- Timeout (TIMEOUT=16): lock on period 5, then stop ticks after cycle t0. Expect a timeout pulse exactly in cycle t0+17 and locked=0, period=0; the next tick only arms (no sample_valid). Repeat with the tick arriving at t0+16: period=16, no timeout.
- Clear vs tick: in TRACK, drive clear and tick in the same cycle. Expect IDLE, period=0, no sample_valid; the following two ticks 3 apart give period=3.
- Async reset mid-operation: drop reset between edges while locked. Expect period, locked and sample_valid all 0 before the next edge; normal operation after release.

Source files
------------

// File: rtl/clock_period_monitor.sv
// Recovers a clock divider's divisor by measuring the cycle distance between
// its enable ticks; reports period, per-measurement strobe, lock and timeout.
module clock_period_monitor #(
  parameter int WIDTH      = 17,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 131071
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  output logic [WIDTH-1:0] period,
  output logic             sample_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_LAST      = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CNT_ONE       = WIDTH'(1);
  localparam logic [3:0]       LOCK_N        = 4'(LOCK_COUNT);
  localparam logic             LOCK_ON_FIRST = (LOCK_COUNT == 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]       match_q, match_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             sample_valid_q, sample_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic [WIDTH-1:0] meas_s;
  logic [3:0]       match_inc_s;
  logic             expire_s;

  // Measurement is cnt+1 so that back-to-back ticks read as period 1.
  assign meas_s      = cnt_q + CNT_ONE;
  assign match_inc_s = (match_q >= LOCK_N) ? LOCK_N : (match_q + 4'd1);
  assign expire_s    = (cnt_q == CNT_LAST);

  // Next-state logic; clear outranks tick, and tick outranks timeout.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    match_d        = match_q;
    period_d       = period_q;
    locked_d       = locked_q;
    sample_valid_d = 1'b0;
    timeout_d      = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      match_d  = 4'd0;
      period_d = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (tick) begin
            state_d = ARMED;
          end else begin
            state_d = IDLE;
          end
        end
        ARMED, TRACK: begin
          if (tick) begin
            cnt_d          = '0;
            sample_valid_d = 1'b1;
            state_d        = TRACK;
            if (state_q == ARMED) begin
              period_d = meas_s;
              match_d  = 4'd1;
              locked_d = LOCK_ON_FIRST;
            end else if (meas_s == period_q) begin
              match_d  = match_inc_s;
              locked_d = (match_inc_s == LOCK_N);
            end else begin
              period_d = meas_s;
              match_d  = 4'd1;
              locked_d = 1'b0;
            end
          end else if (expire_s) begin
            state_d   = IDLE;
            cnt_d     = '0;
            match_d   = 4'd0;
            period_d  = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          match_d  = 4'd0;
          period_d = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      match_q        <= 4'd0;
      period_q       <= '0;
      sample_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      match_q        <= match_d;
      period_q       <= period_d;
      sample_valid_q <= sample_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
    end
  end

  assign period       = period_q;
  assign sample_valid = sample_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_period_monitor.sv
// Scoreboard bench: stimulus queues hand-computed expected events tagged with
// their cycle; a monitor pops and compares whenever a strobe appears.
module tb_clock_period_monitor;

  localparam int W = 17;

  logic         clock;
  logic         reset;
  logic         clear;
  logic         tick;
  logic [W-1:0] period;
  logic         sample_valid;
  logic         locked;
  logic         timeout;

  typedef struct {
    int cyc;
    bit is_to;
    int p;
    bit l;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   total;
  int   bad;

  clock_period_monitor #(.WIDTH(W), .LOCK_COUNT(4), .TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .tick         (tick),
    .period       (period),
    .sample_valid (sample_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, expv);
    end
  endtask

  // One clock cycle with given inputs; inputs change on the falling edge.
  task automatic step(input logic t, input logic c);
    tick  = t;
    clear = c;
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  // Tick cycle expecting a sample (period p, locked l) after this edge.
  task automatic tk(input int p, input bit l);
    exp_t e;
    e.cyc = cyc + 1; e.is_to = 1'b0; e.p = p; e.l = l;
    exp_q.push_back(e);
    step(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic expect_timeout_next();
    exp_t e;
    e.cyc = cyc + 1; e.is_to = 1'b1; e.p = 0; e.l = 1'b0;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every strobe against the queue front, flags misses.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      chk("excl", int'(sample_valid && timeout), 0);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing cyc=%0d got=none want=event@%0d", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (sample_valid || timeout) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("kind_timeout", int'(timeout), int'(e.is_to));
          chk("period", int'(period), e.p);
          chk("locked", int'(locked), int'(e.l));
        end else begin
          total++;
          bad++;
          $display("FAIL unexpected cyc=%0d got=sv%0d/to%0d want=none",
                   cyc, sample_valid, timeout);
        end
      end
    end
  end

  initial begin
    cyc   = 0;
    total = 0;
    bad   = 0;
    tick  = 1'b0;
    clear = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_period", int'(period), 0);
    chk("rst_sv", int'(sample_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Lock on period 5: first tick arms only.
    step(1'b1, 1'b0);
    idle(4); tk(5, 1'b0);
    idle(4); tk(5, 1'b0);
    idle(4); tk(5, 1'b0);
    idle(4); tk(5, 1'b1);
    idle(4); tk(5, 1'b1);

    // Switch to period 7: lock drops, then returns on the fourth 7.
    idle(6); tk(7, 1'b0);
    idle(6); tk(7, 1'b0);
    idle(6); tk(7, 1'b0);
    idle(6); tk(7, 1'b1);

    // Ticks stop: timeout lands on the 16th tick-free edge.
    idle(15);
    expect_timeout_next();
    idle(1);
    chk("to_period", int'(period), 0);
    chk("to_locked", int'(locked), 0);
    idle(3);
    step(1'b1, 1'b0);
    // Longest measurable period wins over the timeout.
    idle(15); tk(16, 1'b0);
    idle(15); tk(16, 1'b0);

    // Clear beats a simultaneous tick.
    idle(2);
    step(1'b1, 1'b1);
    chk("clr_period", int'(period), 0);
    chk("clr_sv", int'(sample_valid), 0);
    step(1'b1, 1'b0);
    idle(2); tk(3, 1'b0);

    // Constant tick after a clear gives period 1.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    tk(1, 1'b0);
    tk(1, 1'b0);
    tk(1, 1'b0);
    tk(1, 1'b1);
    tk(1, 1'b1);

    // Asynchronous reset between edges while locked.
    tick = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_sv", int'(sample_valid), 0);
    @(posedge clock);
    cyc++;
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 1'b0);
    idle(4); tk(5, 1'b0);
    idle(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
